// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// General-purpose up/down event/timer counter. The count runs over 0..MAX and
// at the boundary it either wraps or saturates. An enable prescaler turns every
// PRESCALE enabled cycles into one count step. tc is a registered one-cycle
// pulse that follows each boundary step. boundary_seen is a sticky record that
// a boundary step has happened since the last reset or clear.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX       terminal value, 1 <= MAX <= 2**WIDTH-1
//   SATURATE  0 = wrap at the boundary, 1 = hold at the boundary
//   PRESCALE  enabled cycles per count step (>= 1)
//
// Ports
//   clock          in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   clear          in   synchronous clear (highest priority)
//   load           in   synchronous load of load_value, clamped to MAX
//   load_value     in   [WIDTH-1:0] value to load
//   enable         in   count enable, qualified through the prescaler
//   up             in   1 = increment, 0 = decrement
//   count          out  [WIDTH-1:0] registered count
//   tc             out  registered pulse in the cycle after a boundary step
//   boundary_seen  out  sticky boundary flag
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             boundary_seen
);

  // A 1-bit prescale register is kept even for PRESCALE=1; it simply stays 0.
  localparam int                PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0]  MAX_V   = WIDTH'(MAX);
  localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PRESCALE - 1);
  localparam bit                FULL_RANGE = (MAX == (2**WIDTH - 1));

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             seen_next;
  logic             step;
  logic             at_boundary;
  logic [WIDTH-1:0] load_clamped;

  // When MAX covers the full WIDTH range no load value can exceed it, so the
  // clamp is dropped rather than left as an always-false compare.
  generate
    if (FULL_RANGE) begin : g_no_clamp
      assign load_clamped = load_value;
    end else begin : g_clamp
      assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
    end
  endgenerate

  // A step is at the boundary when it would leave the 0..MAX range.
  assign at_boundary = up ? (count == MAX_V) : (count == '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    pc_next    = pc;
    count_next = count;
    tc_next    = 1'b0;
    seen_next  = boundary_seen;
    step       = 1'b0;

    // Priority: clear > load > prescaled step.
    if (clear) begin
      pc_next    = '0;
      count_next = '0;
      seen_next  = 1'b0;
    end else if (load) begin
      pc_next    = '0;
      count_next = load_clamped;
    end else if (enable) begin
      if (pc == PC_LAST) begin
        pc_next = '0;
        step    = 1'b1;
      end else begin
        pc_next = pc + 1'b1;
      end
    end

    if (step) begin
      if (at_boundary) begin
        tc_next   = 1'b1;
        seen_next = 1'b1;
        if (up) count_next = SATURATE ? MAX_V : '0;
        else    count_next = SATURATE ? '0    : MAX_V;
      end else begin
        count_next = up ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= '0;
      count         <= '0;
      tc            <= 1'b0;
      boundary_seen <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values computed above, independent of order.
      pc            <= pc_next;
      count         <= count_next;
      tc            <= tc_next;
      boundary_seen <= seen_next;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//
// Three instances share clear/load/load_value/up/reset_n and each has its own
// enable:
//   dut 0: WIDTH=4 MAX=9 wrap,     PRESCALE=1
//   dut 1: WIDTH=4 MAX=9 saturate, PRESCALE=1
//   dut 2: WIDTH=4 MAX=9 wrap,     PRESCALE=3
// Stimulus pushes hand-computed expectations (tagged with the clock cycle they
// apply to, or "now" for asynchronous checks) into a scoreboard queue; a
// separate monitor process pops and compares them.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  typedef struct {
    bit          now;
    int          cyc;
    int          dut;
    logic [3:0]  cnt;
    logic        tc;
    logic        bs;
    string       name;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic [2:0] en_v;
  logic       up;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, tc_s, tc_p;
  logic       bs_w, bs_s, bs_p;

  exp_t sb_q[$];
  exp_t m;
  event probe;
  int   cyc_cnt = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  param_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(en_v[0]), .up(up),
    .count(cnt_w), .tc(tc_w), .boundary_seen(bs_w)
  );

  param_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(en_v[1]), .up(up),
    .count(cnt_s), .tc(tc_s), .boundary_seen(bs_s)
  );

  param_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(en_v[2]), .up(up),
    .count(cnt_p), .tc(tc_p), .boundary_seen(bs_p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // ---------------------------------------------------------------------------
  // Monitor: compares every due expectation against the selected instance.
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] g_cnt;
    logic       g_tc;
    logic       g_bs;
    forever begin
      @(negedge clock or probe);
      while (sb_q.size() > 0 && (sb_q[0].now || sb_q[0].cyc <= cyc_cnt)) begin
        m = sb_q.pop_front();
        n_vec++;
        if (!m.now && m.cyc < cyc_cnt) begin
          n_err++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)",
                   m.name, m.cyc, cyc_cnt);
        end else begin
          case (m.dut)
            0:       begin g_cnt = cnt_w; g_tc = tc_w; g_bs = bs_w; end
            1:       begin g_cnt = cnt_s; g_tc = tc_s; g_bs = bs_s; end
            default: begin g_cnt = cnt_p; g_tc = tc_p; g_bs = bs_p; end
          endcase
          if (g_cnt !== m.cnt || g_tc !== m.tc || g_bs !== m.bs) begin
            n_err++;
            $display("FAIL %s (dut%0d): got count=%0d tc=%b seen=%b, expected count=%0d tc=%b seen=%b",
                     m.name, m.dut, g_cnt, g_tc, g_bs, m.cnt, m.tc, m.bs);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Drive one cycle of inputs after the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic drive(input int dut, input logic en, input logic u,
                       input logic ld, input logic [3:0] lv, input logic clr,
                       input logic [3:0] ec, input logic et, input logic eb,
                       input string nm);
    exp_t e;
    @(negedge clock);
    #1;
    en_v       = 3'b000;
    en_v[dut]  = en;
    up         = u;
    load       = ld;
    load_value = lv;
    clear      = clr;
    e.now  = 1'b0;
    e.cyc  = cyc_cnt + 1;
    e.dut  = dut;
    e.cnt  = ec;
    e.tc   = et;
    e.bs   = eb;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Queue an expectation to be checked immediately (no clock edge involved).
  task automatic push_now(input int dut, input logic [3:0] ec, input logic et,
                          input logic eb, input string nm);
    exp_t e;
    e.now  = 1'b1;
    e.cyc  = 0;
    e.dut  = dut;
    e.cnt  = ec;
    e.tc   = et;
    e.bs   = eb;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int pre_en  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int pre_cnt [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    reset_n    = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = 4'd0;
    en_v       = 3'b000;
    up         = 1'b1;

    // Reset state while reset_n is held low across clock edges.
    repeat (2) @(posedge clock);
    #1;
    push_now(0, 4'd0, 1'b0, 1'b0, "reset_wrap");
    push_now(1, 4'd0, 1'b0, 1'b0, "reset_sat");
    push_now(2, 4'd0, 1'b0, 1'b0, "reset_pre");
    ->probe;
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Up count with wrap at MAX=9: 1..9,0,1,2.
    for (int i = 1; i <= 12; i++)
      drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(i % 10), (i == 10), (i >= 10), "wrap_up");

    // Down wrap from 0 to MAX.
    drive(0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, "dn_load0");
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, "dn_wrap");
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1, "dn_8");

    // Saturate up at 9, then saturate down at 0.
    drive(1, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 4'd8, 1'b0, 1'b0, "sat_load8");
    drive(1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, "sat_up9");
    drive(1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, "sat_hold1");
    drive(1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, "sat_hold2");
    drive(1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1, "sat_idle");
    drive(1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, "sat_load0");
    drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, "sat_dn0");

    // Prescale by 3 with enable dropped for two cycles mid-sequence.
    drive(2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, "pre_clear");
    for (int i = 0; i < 11; i++)
      drive(2, 1'(pre_en[i]), 1'b1, 1'b0, 4'd0, 1'b0, 4'(pre_cnt[i]), 1'b0, 1'b0, "prescale");

    // Load clamp and priority (dut 0 was cleared above).
    drive(0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0, 1'b0, "clamp15");
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b1, "wrap_after_clamp");
    drive(0, 1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 4'd4, 1'b0, 1'b1, "load_beats_step");
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd5, 1'b0, 1'b1, "step_after_load");
    drive(0, 1'b1, 1'b1, 1'b1, 4'd7,  1'b1, 4'd0, 1'b0, 1'b0, "clear_beats_all");

    // Asynchronous reset mid-count at count=5.
    for (int i = 1; i <= 5; i++)
      drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, "pre_reset_count");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    push_now(0, 4'd0, 1'b0, 1'b0, "async_reset");
    ->probe;
    @(posedge clock);
    #1;
    push_now(0, 4'd0, 1'b0, 1'b0, "reset_holds");
    ->probe;
    @(negedge clock);
    #1;
    en_v    = 3'b000;
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, "post_reset_step");
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0, "post_reset_step2");

    // Let the monitor drain every queued expectation.
    repeat (3) @(negedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter: the successor to the 4-bit enable-only counter. It adds configurable width and modulus, direction control, synchronous load and clear, a wrap or saturate boundary mode, an enable prescaler, a registered terminal-count pulse and a sticky boundary flag. It serves as the general-purpose event/timer counter in lab datapaths and as the tick generator for later timer and baud blocks.

## Interface
- WIDTH, 8, counter width in bits; must be ≥2.
- MAX, 2**WIDTH-1, terminal value; the count range is 0..MAX; requires 1 ≤ MAX ≤ 2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at the boundary.
- PRESCALE, 1, number of enabled cycles per count step; must be ≥1.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- enable  input  1  count enable, qualified through the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- count  output  WIDTH  current count, registered.
- tc  output  1  one-cycle registered pulse following a boundary step.
- boundary_seen  output  1  sticky flag: a boundary step has occurred since the last reset or clear.

## Operation
- Reset (reset_n low, asynchronous):
  - count = 0, tc = 0, boundary_seen = 0, prescale counter = 0.
  - Outputs hold these values for as long as reset_n stays low.
- Per-edge priority is clear > load > step.
- clear:
  - count = 0, prescale counter = 0, boundary_seen = 0, tc = 0.
- load (with clear low):
  - count = min(load_value, MAX).
  - prescale counter = 0, tc = 0.
  - boundary_seen is unchanged.
- Prescaler:
  - The internal counter pc spans 0..PRESCALE-1 and advances only on cycles where enable=1 and neither clear nor load is active.
  - A step occurs on an enabled cycle where pc == PRESCALE-1; pc then returns to 0.
  - With PRESCALE=1, every enabled cycle is a step.
  - enable low freezes both pc and count.
- Step with up=1:
  - count < MAX: count+1.
  - count == MAX: becomes 0 (SATURATE=0) or stays MAX (SATURATE=1). This is a boundary step.
- Step with up=0:
  - count > 0: count-1.
  - count == 0: becomes MAX (SATURATE=0) or stays 0 (SATURATE=1). This is a boundary step.
- tc:
  - Registered; equals 1 in the cycle after a boundary step, otherwise 0.
  - Under saturation, tc pulses on every step attempted at the boundary.
- boundary_seen:
  - Set on any boundary step.
  - Cleared only by reset_n or clear.
- Direction changes take effect on the next step and do not disturb pc.
- Arithmetic is modulo MAX+1 in wrap mode. count never exceeds MAX. Comparisons are unsigned, WIDTH bits.

## Timing
- Latency: count reflects a step, load or clear on the same rising edge, and is visible in the following cycle.
- tc rises on the same edge that performs the boundary update. It is high for exactly one cycle unless boundary steps occur on consecutive cycles.
- No combinational path from inputs to outputs.
- Reset mid-count:
  - Outputs go to zero asynchronously on the falling edge of reset_n.
  - Release is synchronous to clock. The first step can occur no earlier than the first rising edge with reset_n high.
- Simultaneous events:
  - clear together with load together with enable: clear wins.
  - load together with enable: the loaded value is taken, and no step occurs that cycle.

## Test plan
- Reset, wrap at modulus (WIDTH=4, MAX=9, PRESCALE=1, up=1, enable=1 for 12 cycles from reset):
  - count sequence 1..9,0,1,2.
  - tc high only in the cycle where count shows 0.
  - boundary_seen=1 from that cycle on.
- Down wrap (same parameters, load 0, then up=0, enable for 2 cycles):
  - count = 9, then 8.
  - tc pulses once, in the cycle count=9.
- Saturate (SATURATE=1, MAX=9, load 8, up=1, enable for 3 cycles):
  - count = 9, 9, 9.
  - tc high on the 2nd and 3rd cycles.
- Prescale (PRESCALE=3, enable high for 9 cycles, then enable low for 2 cycles mid-sequence):
  - count increments once per 3 enabled cycles, ending at 3.
  - count is frozen while enable is low.
- Priority and clamp:
  - load_value=15 with MAX=9 gives count=9.
  - clear+load+enable together gives count=0, boundary_seen=0.
  - load+enable together gives count=load_value, with no step that cycle.
- Asynchronous reset mid-count at count=5: count=0 immediately, before the next clock edge. After release, counting resumes from 0 at the first enabled edge.
